// File: rtl/iterative_shift_unit_pkg.sv
// Shared encodings for the iterative shifter.
// Op and FSM state enums used by the unit and its bench.
package iterative_shift_unit_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iterative_shift_unit_if.sv
// Request/response handshake bundle for the iterative shifter.
// The master issues operations, the slave returns results.
interface iterative_shift_unit_if
  import iterative_shift_unit_pkg::*;
#(
  parameter int N = 32
) ();

  localparam int SHAMT_W = $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       a;
  logic [SHAMT_W-1:0] shamt;
  op_e                op;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       result;

  modport master (
    output in_valid,
    output a,
    output shamt,
    output op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  a,
    input  shamt,
    input  op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );

endinterface

// File: rtl/iterative_shift_unit_step.sv
// One combinational shift step of 0..STEP bits.
// SRA fills with d[N-1], ROR wraps LSB bits to the MSB.
module iterative_shift_unit_step
  import iterative_shift_unit_pkg::*;
#(
  parameter int N     = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [N-1:0]     d,
  input  logic [AMT_W-1:0] amt,
  input  op_e              op,
  output logic [N-1:0]     q
);

  always_comb begin
    q = '0;
    unique case (1'b1)
      (op == OP_SLL): q = d << amt;
      (op == OP_SRL): q = d >> amt;
      (op == OP_SRA): q = $signed(d) >>> amt;
      (op == OP_ROR): q = (d >> amt)
                        | (d << (N - int'(amt)));
      default:        q = '0;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR unit, STEP bits per cycle.
// Single-entry occupancy with valid/ready on both sides and flush.
module iterative_shift_unit
  import iterative_shift_unit_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  iterative_shift_unit_if.slave bus,
  output logic busy
);

  localparam int SHAMT_W = $clog2(N);
  localparam int AMT_W   = $clog2(STEP + 1);
  localparam logic [31:0] STEP32 = 32'(STEP);

  state_e             state;
  state_e             state_n;
  logic [N-1:0]       res_q;
  op_e                op_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] rem_n;
  logic [AMT_W-1:0]   s;
  logic [31:0]        rem32;
  logic [N-1:0]       step_q;
  logic               accept;

  assign accept = bus.in_valid
                & (state == S_IDLE)
                & ~flush;

  // s = min(STEP, remaining), done at 32 bits so STEP==N fits
  always_comb begin
    rem32 = 32'(rem_q);
    if (rem32 >= STEP32)
      s = STEP32[AMT_W-1:0];
    else
      s = rem32[AMT_W-1:0];
    rem_n = SHAMT_W'(rem32 - 32'(s));
  end

  iterative_shift_unit_step #(
    .N    (N),
    .STEP (STEP),
    .AMT_W(AMT_W)
  ) u_step (
    .d  (res_q),
    .amt(s),
    .op (op_q),
    .q  (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (bus.in_valid)
          state_n = (bus.shamt == '0)
                  ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (rem_n == '0)
          state_n = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (flush)
      state_n = S_IDLE;
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    busy          = (state != S_IDLE);
  end

  // flush leaves result as-is; only state is aborted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      op_q  <= OP_SLL;
      rem_q <= '0;
    end else if (accept) begin
      res_q <= bus.a;
      op_q  <= bus.op;
      rem_q <= bus.shamt;
    end else if (state == S_SHIFT && !flush) begin
      res_q <= step_q;
      rem_q <= rem_n;
    end
  end

  assign bus.result = res_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Scoreboard bench for iterative_shift_unit (N=32, STEP=4).
// Directed vectors push expectations; a monitor pops and checks.
module tb_iterative_shift_unit;
  import iterative_shift_unit_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   cyc;
  int   checks;
  int   passed;
  exp_t sb[$];

  iterative_shift_unit_if #(.N(32)) bus ();

  iterative_shift_unit #(
    .N   (32),
    .STEP(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name,
                       input op_e o,
                       input logic [31:0] av,
                       input logic [4:0] sh,
                       input logic [31:0] er,
                       input int lat);
    exp_t e;
    int n;
    tick();
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.shamt    = sh;
    bus.op       = o;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail_now({name, "_accept"});
    e.res  = er;
    e.acc  = cyc;
    e.lat  = lat;
    e.name = name;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = $urandom();
    bus.shamt    = 5'($urandom());
    bus.op       = op_e'($urandom_range(0, 3));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.in_ready)
           && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) fail_now({name, "_drain"});
  endtask

  initial begin : monitor
    exp_t e;
    int   first;
    bit   have;
    logic [31:0] held;
    have = 1'b0;
    first = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else if (bus.out_valid) begin
        if (!have) begin
          have  = 1'b1;
          first = cyc;
          held  = bus.result;
        end else begin
          chk("hold", bus.result, held);
        end
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out_valid: got result %h, expected none",
                     bus.result);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_res"}, bus.result, e.res);
            chk({e.name, "_lat"}, 32'(first - e.acc),
                32'(e.lat));
          end
          have = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.shamt     = '0;
    bus.op        = OP_SLL;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_result", bus.result, 0);
    tick();
    tick();
    rst_n = 1'b1;

    issue("sll5", OP_SLL, 32'h1, 5,
          32'h20, 3);
    issue("sra31", OP_SRA, 32'h8000_0000, 31,
          32'hFFFF_FFFF, 9);
    issue("srl31", OP_SRL, 32'h8000_0000, 31,
          32'h1, 9);
    issue("ror4", OP_ROR, 32'hF1, 4,
          32'h1000_000F, 2);
    issue("ror8", OP_ROR, 32'h1234_5678, 8,
          32'h7812_3456, 3);
    issue("sll31", OP_SLL, 32'hFFFF_FFFF, 31,
          32'h8000_0000, 9);
    issue("sra3", OP_SRA, 32'h7FFF_FFFF, 3,
          32'h0FFF_FFFF, 2);
    issue("sra1", OP_SRA, 32'h8000_0000, 1,
          32'hC000_0000, 2);
    issue("ror31", OP_ROR, 32'h1, 31,
          32'h2, 9);
    issue("srl28", OP_SRL, 32'hF000_0000, 28,
          32'hF, 8);
    wait_idle("vec");

    // stalled consumer on a zero-length op
    bus.out_ready = 1'b0;
    issue("srl0", OP_SRL, 32'hDEAD_BEEF, 0,
          32'hDEAD_BEEF, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_result", bus.result,
          32'hDEAD_BEEF);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("turn_in_ready", 32'(bus.in_ready), 1);
    chk("turn_busy", 32'(busy), 0);
    wait_idle("stall");

    // flush in the 2nd SHIFT cycle with a competing request
    tick();
    chk("fl_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a        = 32'h0000_00FF;
    bus.shamt    = 5'd20;
    bus.op       = OP_SLL;
    tick();
    bus.in_valid = 1'b0;
    chk("fl_shift1", 32'(busy), 1);
    tick();
    chk("fl_shift2", 32'(busy), 1);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 32'h5555_5555;
    bus.shamt    = 5'd0;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_idle_busy", 32'(busy), 0);
    chk("fl_idle_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      chk("fl_no_valid", 32'(bus.out_valid), 0);
      chk("fl_no_accept", 32'(busy), 0);
      tick();
    end

    // async reset in the middle of SHIFT
    issue("rstmid", OP_SRA, 32'h8000_0000, 31,
          32'hFFFF_FFFF, 9);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("ar_out_valid", 32'(bus.out_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_in_ready", 32'(bus.in_ready), 1);
    chk("ar_result", bus.result, 0);
    tick();
    tick();
    rst_n = 1'b1;
    issue("post_rst", OP_SRL, 32'h8000_0000, 31,
          32'h1, 9);
    wait_idle("post_rst");
    tick();
    chk("end_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
